// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and constants for the product accumulator
package mac_pkg;

  typedef enum logic {
    MAC_ACC = 1'b0,
    MAC_OUT = 1'b1
  } mac_state_e;

  localparam int MAC_ACC_W     = 12;
  localparam int MAC_MAX_TERMS = 16;

  // Width needed to hold a term count of 0..max_terms inclusive.
  function automatic int mac_count_w(input int max_terms);
    return $clog2(max_terms + 1);
  endfunction

endpackage

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - sums multiplier products into one result per group
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W     = MAC_ACC_W,
  parameter int MAX_TERMS = MAC_MAX_TERMS,
  localparam int CNT_W    = mac_count_w(MAX_TERMS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       product,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  mac_state_e       state, next_state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             accept;
  logic             closing;
  logic             xfer;

  assign sum     = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, product};
  assign accept  = in_valid && in_ready;
  // last and the term limit may coincide; either alone closes the group.
  assign closing = last || (cnt == CNT_W'(MAX_TERMS - 1));
  assign xfer    = (state == MAC_OUT) && out_ready;

  always_comb begin
    next_state = state;
    case (state)
      MAC_ACC: if (accept && closing) next_state = MAC_OUT;
      MAC_OUT: if (out_ready) next_state = MAC_ACC;
      default: next_state = MAC_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MAC_ACC;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst || xfer) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= sum[ACC_W-1:0];
      cnt <= cnt + 1'b1;
      ovf <= ovf | sum[ACC_W];
    end
  end

  // Handshake outputs decode the state register; rst only masks acceptance.
  assign in_ready     = (state == MAC_ACC) && !rst;
  assign out_valid    = (state == MAC_OUT);
  assign out_sum      = acc;
  assign out_count    = cnt;
  assign out_overflow = ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - randomized and directed bench for mac_accumulator
module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] product = 8'd0;

  logic        in_ready0, out_valid0, ovf0;
  logic [11:0] sum0;
  logic [4:0]  count0;
  logic        in_ready1, out_valid1, ovf1;
  logic [9:0]  sum1;
  logic [4:0]  count1;

  mac_accumulator #(.ACC_W(12), .MAX_TERMS(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .product(product), .last(last), .out_valid(out_valid0), .out_ready(out_ready),
    .out_sum(sum0), .out_count(count0), .out_overflow(ovf0)
  );

  mac_accumulator #(.ACC_W(10), .MAX_TERMS(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .product(product), .last(last), .out_valid(out_valid1), .out_ready(out_ready),
    .out_sum(sum1), .out_count(count1), .out_overflow(ovf1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: plain integer total of the open group and the pending result.
  int tot = 0;
  int n = 0;
  bit pend = 0;
  int p_tot = 0;
  int p_n = 0;

  logic [31:0] obs_sum0, obs_cnt0, obs_ovf0, obs_sum1, obs_ovf1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] p, input bit l, input bit r);
    bit acc_ok, xfer;
    in_valid  = v;
    product   = p;
    last      = l;
    out_ready = r;
    #1;
    chk("in_ready0", 32'(in_ready0), 32'(!pend));
    chk("out_valid0", 32'(out_valid0), 32'(pend));
    chk("in_ready1", 32'(in_ready1), 32'(!pend));
    chk("out_valid1", 32'(out_valid1), 32'(pend));
    if (pend) begin
      chk("out_sum0", 32'(sum0), 32'(p_tot % 4096));
      chk("out_count0", 32'(count0), 32'(p_n));
      chk("out_ovf0", 32'(ovf0), 32'(p_tot >= 4096));
      chk("out_sum1", 32'(sum1), 32'(p_tot % 1024));
      chk("out_count1", 32'(count1), 32'(p_n));
      chk("out_ovf1", 32'(ovf1), 32'(p_tot >= 1024));
    end
    acc_ok = v && !pend;
    xfer   = pend && r;
    if (xfer) begin
      obs_sum0 = 32'(sum0);
      obs_cnt0 = 32'(count0);
      obs_ovf0 = 32'(ovf0);
      obs_sum1 = 32'(sum1);
      obs_ovf1 = 32'(ovf1);
    end
    @(posedge clk);
    if (xfer) pend = 0;
    if (acc_ok) begin
      tot += int'(p);
      n++;
      if (l || n == 16) begin
        pend  = 1;
        p_tot = tot;
        p_n   = n;
        tot   = 0;
        n     = 0;
      end
    end
    #1;
  endtask

  task automatic rst_cyc();
    rst       = 1'b1;
    in_valid  = 1'b1;
    product   = 8'($urandom);
    last      = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("in_ready0 in rst", 32'(in_ready0), 32'd0);
    chk("in_ready1 in rst", 32'(in_ready1), 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    tot  = 0;
    n    = 0;
    pend = 0;
    #1;
    chk("rst out_valid", 32'(out_valid0), 32'd0);
    chk("rst out_count", 32'(count0), 32'd0);
    chk("rst out_sum", 32'(sum0), 32'd0);
    chk("rst out_ovf", 32'(ovf0), 32'd0);
    chk("rst in_ready", 32'(in_ready0), 32'd1);
  endtask

  initial begin
    rst_cyc();

    // Three-term group with last on the third beat.
    cyc(1, 8'd10, 0, 1);
    cyc(1, 8'd20, 0, 1);
    cyc(1, 8'd30, 1, 1);
    cyc(0, 8'd0, 0, 1);
    chk("grp3 sum", obs_sum0, 32'd60);
    chk("grp3 count", obs_cnt0, 32'd3);
    chk("grp3 ovf", obs_ovf0, 32'd0);
    chk("grp3 in_ready after xfer", 32'(in_ready0), 32'd1);

    // Automatic close after sixteen beats.
    for (int i = 0; i < 16; i++) cyc(1, 8'd255, 0, 1);
    cyc(0, 8'd0, 0, 1);
    chk("auto sum", obs_sum0, 32'd4080);
    chk("auto count", obs_cnt0, 32'd16);
    chk("auto ovf", obs_ovf0, 32'd0);

    // Back-pressure on the result while upstream keeps offering beats.
    cyc(1, 8'd1, 0, 0);
    cyc(1, 8'd2, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'd99, 0, 0);
    cyc(1, 8'd99, 0, 1);
    chk("hold sum", obs_sum0, 32'd3);
    chk("hold count", obs_cnt0, 32'd2);
    cyc(1, 8'd5, 1, 1);
    cyc(0, 8'd0, 0, 1);
    chk("post-hold sum", obs_sum0, 32'd5);
    chk("post-hold count", obs_cnt0, 32'd1);

    // Narrow accumulator wraps and flags overflow; next group is clean.
    for (int i = 0; i < 4; i++) cyc(1, 8'd255, 0, 1);
    cyc(1, 8'd255, 1, 1);
    cyc(0, 8'd0, 0, 1);
    chk("w10 sum", obs_sum1, 32'd251);
    chk("w10 ovf", obs_ovf1, 32'd1);
    chk("w12 sum", obs_sum0, 32'd1275);
    cyc(1, 8'd1, 1, 1);
    cyc(0, 8'd0, 0, 1);
    chk("w10 next sum", obs_sum1, 32'd1);
    chk("w10 next ovf", obs_ovf1, 32'd0);

    // Reset mid-group discards the partial sum.
    cyc(1, 8'd50, 0, 1);
    cyc(1, 8'd60, 0, 1);
    rst_cyc();
    cyc(1, 8'd7, 1, 1);
    cyc(0, 8'd0, 0, 1);
    chk("post-rst sum", obs_sum0, 32'd7);
    chk("post-rst count", obs_cnt0, 32'd1);

    // Gaps in in_valid; product and last are ignored on idle cycles.
    cyc(1, 8'd3, 0, 1);
    cyc(0, 8'($urandom), 1, 1);
    cyc(1, 8'd4, 0, 1);
    cyc(0, 8'($urandom), 1, 1);
    cyc(1, 8'd5, 1, 1);
    cyc(0, 8'd0, 0, 1);
    chk("gap sum", obs_sum0, 32'd12);
    chk("gap count", obs_cnt0, 32'd3);

    // last on the sixteenth beat closes the group exactly once.
    for (int i = 0; i < 15; i++) cyc(1, 8'd1, 0, 1);
    cyc(1, 8'd1, 1, 1);
    cyc(0, 8'd0, 0, 1);
    chk("both sum", obs_sum0, 32'd16);
    chk("both count", obs_cnt0, 32'd16);
    cyc(0, 8'd0, 0, 1);

    // Reset while a result is pending drops it.
    cyc(1, 8'd9, 1, 0);
    rst_cyc();
    cyc(0, 8'd0, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 3; i++) cyc(0, 8'd0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Accumulates the 8-bit products emitted by the 4x4 combinational multiplier into a wider running sum and delivers one result per group of terms. It sits directly downstream of the multiplier: upstream logic presents `product` with a valid/ready handshake, and this block returns the group sum over a second valid/ready handshake. A group ends on a beat tagged `last`, or automatically after `MAX_TERMS` beats.

## Interface
- `ACC_W`, 12, accumulator and result width in bits; must be >= 8.
- `MAX_TERMS`, 16, maximum number of beats per group; the group closes automatically when this count is reached.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream presents a product.
- `in_ready`  out  1  block can accept a beat.
- `product`  in  8  unsigned product term (A*B).
- `last`  in  1  qualifies `product`; marks the final term of the group.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  ACC_W  group sum, modulo 2^ACC_W.
- `out_count`  out  $clog2(MAX_TERMS+1)  number of terms in the group.
- `out_overflow`  out  1  sticky flag: at least one carry left bit ACC_W-1 during the group.

## Operation
- A beat is accepted when `in_valid && in_ready`. `out_*` transfers when `out_valid && out_ready`.
- The FSM has two states.
  - ACC: `in_ready`=1 and `out_valid`=0. On each accepted beat, `acc <= acc + {0,product}` (zero-extended to ACC_W+1 bits). The carry bit ORs into `ovf`, and `cnt <= cnt+1`.
  - If the accepted beat has `last`=1, or `cnt == MAX_TERMS-1`, the block moves to OUT. Both conditions together close the group once, with an identical result.
  - OUT: `in_ready`=0 and `out_valid`=1. `out_sum`, `out_count` and `out_overflow` are driven from `acc`, `cnt` and `ovf`, and hold stable until transfer.
  - On transfer, the block clears `acc`, `cnt` and `ovf` and returns to ACC.
- Cycles with `in_valid`=0 leave all state unchanged. `product` and `last` are ignored when the beat is not accepted.
- A group always contains at least one term, so an empty result is never produced.
- Arithmetic is unsigned and wraps. With the defaults, 16×255 = 4080 fits in 12 bits, so `out_overflow` can only assert when ACC_W < 8 + $clog2(MAX_TERMS).
- Reset, in any state including mid-group and during OUT, takes effect at the clock edge:
  - state becomes ACC;
  - `acc`, `cnt` and `ovf` become 0;
  - `out_valid` becomes 0;
  - any partial group is discarded and the pending result is dropped.
- While `rst`=1, `in_ready` is forced to 0.

## Timing
- Reset values of the outputs: `in_ready`=1 from the first cycle after reset is released; `out_valid`=0; `out_sum`=0; `out_count`=0; `out_overflow`=0.
- Latency: `out_valid` rises in the cycle after the edge that accepts the closing beat.
- `in_ready` is decoded from state only. It has no combinational path from `out_ready` or `in_valid`.
- Throughput:
  - 1 beat per cycle within a group.
  - At least one bubble per group: the OUT cycle.
  - With `out_ready` held at 1, a group of N terms occupies N+1 cycles.
- `out_valid` never drops without a transfer or a reset. Outputs are registered.
- `in_ready` returns to 1 in the cycle after the transfer. A beat presented during OUT is held off by the upstream, not lost.

## Structure
- Shared package `mac_pkg` contains:
  - the state enum (`MAC_ACC`, `MAC_OUT`);
  - default constants `MAC_ACC_W`=12 and `MAC_MAX_TERMS`=16;
  - the count-width function.
- Single module, no sub-modules. The ACC_W+1-bit adder is inline. The 4-bit `addition` cell is not reused because its width does not match.

## Test plan
- Group 10, 20, 30 with `last` on the third beat and `out_ready`=1 → `out_valid` one cycle later with `out_sum`=60, `out_count`=3, `out_overflow`=0; `in_ready`=1 again on the following cycle.
- 16 beats of 255 with no `last` → automatic close, `out_sum`=4080, `out_count`=16, `out_overflow`=0.
- Hold `out_ready`=0 for 5 cycles after `out_valid` while `in_valid`=1 → outputs stable, `in_ready`=0, no beat accepted. Release → transfer, then the next beat is accepted and counted in a new group.
- ACC_W=10: five beats of 255 with `last` on the fifth → `out_sum`=251 (1275 mod 1024), `out_overflow`=1. The next group of 1 with `last` gives `out_sum`=1 and `out_overflow`=0.
- Assert `rst` for one cycle after 2 accepted beats → `out_valid`=0 and `out_count`=0. A following single beat 7 with `last` → `out_sum`=7, `out_count`=1.
- Toggle `in_valid` as 1,0,1,0,1 with products 3, x, 4, x, 5 and `last` on the final beat → `out_sum`=12, `out_count`=3.
